// File: rtl/pdm_pkg.sv
// Shared constants and helpers for the PCM-to-PDM transmit path.
package pdm_pkg;

  localparam int IN_W_DEF = 16;
  localparam int LMAX     = 10;

  function automatic int acc_w(input int in_w, input int lmax);
    return in_w + lmax + 2;
  endfunction

  // Adding 2^(w-1) to a w-bit two's complement value is the same as flipping its MSB.
  function automatic logic [31:0] to_offset(input logic [31:0] y, input int w);
    return y ^ (32'd1 << (w - 1));
  endfunction

endpackage

// File: rtl/sigma_delta_mod1.sv
// First-order sigma-delta modulator: the carry out of an unsigned accumulator is the PDM bit.
module sigma_delta_mod1
  import pdm_pkg::*;
#(
  parameter int W = IN_W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         strobe_i,
  input  logic         clear_i,
  input  logic [W-1:0] u_i,
  output logic         pdm_o
);

  logic [W-1:0] acc_q, acc_d;
  logic         pdm_q, pdm_d;
  logic [W:0]   sum;

  always_comb begin
    sum   = {1'b0, acc_q} + {1'b0, u_i};
    acc_d = acc_q;
    pdm_d = pdm_q;
    if (clear_i) begin
      acc_d = '0;
      pdm_d = 1'b0;
    end else if (strobe_i) begin
      acc_d = sum[W-1:0];
      pdm_d = sum[W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      pdm_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      pdm_q <= pdm_d;
    end
  end

  assign pdm_o = pdm_q;

endmodule

// File: rtl/pcm_to_pdm.sv
// PCM to PDM: one-entry holding register, 2-stage CIC interpolator (R = 2^L), first-order modulator.
module pcm_to_pdm #(
  parameter int IN_W  = pdm_pkg::IN_W_DEF,
  parameter int LMAX  = pdm_pkg::LMAX,
  parameter int ACC_W = pdm_pkg::acc_w(IN_W, LMAX)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clk_en,
  input  logic [IN_W-1:0] in_data,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      rate_log2,
  input  logic            rate_we,
  output logic            pdm_out,
  output logic            underrun,
  input  logic            underrun_clr
);

  localparam int             PH_W   = (LMAX > 0) ? LMAX : 1;
  localparam logic [PH_W:0]  PH_ONE = 1;
  localparam logic [3:0]     LMAX_4 = 4'(LMAX);

  logic [IN_W-1:0]         hold_q, hold_d;
  logic                    full_q, full_d;
  logic [3:0]              l_q, l_d;
  logic [PH_W-1:0]         phase_q, phase_d;
  logic signed [ACC_W-1:0] x_d_q, x_d_d, c1_d_q, c1_d_d, c2_r_q, c2_r_d;
  logic signed [ACC_W-1:0] i1_q, i1_d, i2_q, i2_d;
  logic                    stuff_q, stuff_d;
  logic                    underrun_q, underrun_d;

  logic                    strobe, consume, take;
  logic [PH_W:0]           last_ph;
  logic signed [ACC_W-1:0] x, c1, c2;
  logic signed [IN_W-1:0]  y_w;
  logic [IN_W-1:0]         u_w;

  // A rate write flushes the filter, so it also suppresses any coincident strobe.
  assign strobe   = clk_en && !rate_we;
  assign consume  = strobe && (phase_q == '0);
  assign in_ready = !full_q;
  assign take     = in_valid && !full_q;
  assign last_ph  = (PH_ONE << l_q) - PH_ONE;

  // An empty register repeats the previous sample.
  assign x  = full_q ? {{(ACC_W-IN_W){hold_q[IN_W-1]}}, hold_q} : x_d_q;
  assign c1 = x - x_d_q;
  assign c2 = c1 - c1_d_q;

  assign y_w = IN_W'(i2_q >>> l_q);
  assign u_w = IN_W'(pdm_pkg::to_offset(32'(y_w), IN_W));

  always_comb begin
    hold_d     = hold_q;
    full_d     = full_q;
    l_d        = l_q;
    phase_d    = phase_q;
    x_d_d      = x_d_q;
    c1_d_d     = c1_d_q;
    c2_r_d     = c2_r_q;
    i1_d       = i1_q;
    i2_d       = i2_q;
    stuff_d    = stuff_q;
    underrun_d = underrun_q;

    if (rate_we) begin
      l_d     = (rate_log2 > LMAX_4) ? LMAX_4 : rate_log2;
      phase_d = '0;
      x_d_d   = '0;
      c1_d_d  = '0;
      c2_r_d  = '0;
      i1_d    = '0;
      i2_d    = '0;
      stuff_d = 1'b0;
    end else if (strobe) begin
      i1_d    = i1_q + (stuff_q ? c2_r_q : '0);
      i2_d    = i2_q + i1_q;
      stuff_d = consume;
      phase_d = ({1'b0, phase_q} == last_ph) ? '0 : phase_q + 1'b1;
      if (consume) begin
        x_d_d  = x;
        c1_d_d = c1;
        c2_r_d = c2;
      end
    end

    if (consume && full_q) full_d = 1'b0;
    if (underrun_clr) underrun_d = 1'b0;
    if (consume && !full_q) underrun_d = 1'b1;
    if (take) begin
      full_d = 1'b1;
      hold_d = in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q     <= '0;
      full_q     <= 1'b0;
      l_q        <= '0;
      phase_q    <= '0;
      x_d_q      <= '0;
      c1_d_q     <= '0;
      c2_r_q     <= '0;
      i1_q       <= '0;
      i2_q       <= '0;
      stuff_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      hold_q     <= hold_d;
      full_q     <= full_d;
      l_q        <= l_d;
      phase_q    <= phase_d;
      x_d_q      <= x_d_d;
      c1_d_q     <= c1_d_d;
      c2_r_q     <= c2_r_d;
      i1_q       <= i1_d;
      i2_q       <= i2_d;
      stuff_q    <= stuff_d;
      underrun_q <= underrun_d;
    end
  end

  assign underrun = underrun_q;

  sigma_delta_mod1 #(.W(IN_W)) u_mod (
    .clk      (clk),
    .rst_n    (rst_n),
    .strobe_i (strobe),
    .clear_i  (rate_we),
    .u_i      (u_w),
    .pdm_o    (pdm_out)
  );

endmodule
